// File: rtl/hr_local_inject_queue.sv
// rtl/hr_local_inject_queue.sv - per-local-port injection FIFO feeding a hierarchical-ring node
// Holds the head flit until the node acks it, and tracks head starvation for throttling.
module hr_local_inject_queue #(
   parameter int FLIT_W    = 144,
   parameter int VALID_BIT = 143,
   parameter int DEPTH     = 4,
   parameter int STARVE_W  = 8,
   parameter int STARVE_TH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [FLIT_W-1:0]        in_flit,
   output logic                     in_ready,
   output logic [FLIT_W-1:0]        port_local_o,
   input  logic                     port_ack,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     starve,
   output logic                     err_ack
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
   localparam logic [STARVE_W:0]   TH_EXT   = (STARVE_W + 1)'(STARVE_TH);

   logic [FLIT_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [CNT_W-1:0]    cnt;
   logic [STARVE_W-1:0] scnt;
   logic [STARVE_W-1:0] scnt_next;
   logic                starve_q;
   logic                err_q;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;
   logic [FLIT_W-1:0]   wr_flit;

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);
   assign push  = in_valid && !full;
   assign pop   = port_ack && !empty;

   assign in_ready     = !full;
   assign port_local_o = empty ? '0 : mem[rd_ptr];
   assign count        = cnt;
   assign starve       = starve_q;
   assign err_ack      = err_q;

   always_comb begin
      wr_flit            = in_flit;
      wr_flit[VALID_BIT] = 1'b1;
   end

   // A non-empty queue that is not popping is by construction seeing port_ack=0.
   always_comb begin
      scnt_next = scnt;
      if (empty || pop) begin
         scnt_next = '0;
      end else if (scnt != '1) begin
         scnt_next = scnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_flit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         scnt     <= '0;
         starve_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         scnt     <= scnt_next;
         starve_q <= ({1'b0, scnt_next} >= TH_EXT);
         if (port_ack && empty) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hr_local_inject_queue.sv
// tb/tb_hr_local_inject_queue.sv - directed self-checking bench for hr_local_inject_queue
module tb_hr_local_inject_queue;

   localparam int FW = 144;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [FW-1:0] in_flit;
   logic          in_ready;
   logic [FW-1:0] port_local_o;
   logic          port_ack;
   logic [2:0]    count;
   logic          starve;
   logic          err_ack;

   int errors = 0;
   int checks = 0;
   logic [FW-1:0] q[$];
   logic [FW-1:0] f1;

   hr_local_inject_queue dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_flit      (in_flit),
      .in_ready     (in_ready),
      .port_local_o (port_local_o),
      .port_ack     (port_ack),
      .count        (count),
      .starve       (starve),
      .err_ack      (err_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FW-1:0] raw(input int p);
      logic [FW-1:0] v;
      v = '0;
      v[31:0] = p;
      return v;
   endfunction

   function automatic logic [FW-1:0] mk(input int p);
      logic [FW-1:0] v;
      v = raw(p);
      v[143] = 1'b1;
      return v;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_flit = mk(8'h77); port_ack = 1'b0;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_count", FW'(count), 0);
      chk("rst_ready", FW'(in_ready), 1);
      chk("rst_port", port_local_o, '0);
      chk("rst_starve", FW'(starve), 0);
      chk("rst_err", FW'(err_ack), 0);
      tick();
      chk("rst_nostore", FW'(count), 0);

      // single inject, held three cycles, then acked
      f1 = mk(8'hA5);
      in_flit = f1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_c1", port_local_o, f1);
      chk("single_cnt", FW'(count), 1);
      tick();
      chk("single_c2", port_local_o, f1);
      tick();
      chk("single_c3", port_local_o, f1);
      port_ack = 1'b1;
      tick();
      port_ack = 1'b0;
      chk("single_cnt0", FW'(count), 0);
      chk("single_idle", port_local_o, '0);

      // fill with valid bit clear on input; the fifth is refused
      for (int i = 1; i <= 5; i++) begin
         in_flit = raw(i); in_valid = 1'b1;
         chk($sformatf("fill_ready%0d", i), FW'(in_ready), (i <= 4) ? 1 : 0);
         tick();
      end
      in_valid = 1'b0;
      chk("fill_cnt", FW'(count), 4);
      chk("fill_notready", FW'(in_ready), 0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain%0d", i), port_local_o, mk(i));
         port_ack = 1'b1;
         tick();
         port_ack = 1'b0;
      end
      chk("drain_empty", FW'(count), 0);

      // full with simultaneous ack, then 12 push+pop cycles across pointer wrap
      for (int i = 10; i <= 13; i++) begin
         in_flit = raw(i); in_valid = 1'b1;
         q.push_back(mk(i));
         tick();
      end
      in_flit = raw(14); in_valid = 1'b1; port_ack = 1'b1;
      chk("full_ready", FW'(in_ready), 0);
      chk("full_head", port_local_o, q[0]);
      tick();
      void'(q.pop_front());
      chk("full_pop_cnt", FW'(count), 3);
      for (int k = 0; k < 12; k++) begin
         in_flit = raw(20 + k);
         chk($sformatf("wrap_head%0d", k), port_local_o, q[0]);
         tick();
         void'(q.pop_front());
         q.push_back(mk(20 + k));
         chk($sformatf("wrap_cnt%0d", k), FW'(count), 3);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wrap_drain%0d", k), port_local_o, q[0]);
         tick();
         void'(q.pop_front());
      end
      port_ack = 1'b0;
      chk("wrap_empty", FW'(count), 0);
      chk("wrap_idle", port_local_o, '0);

      // starvation
      in_flit = raw(16'hBEEF); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("starve_start", FW'(starve), 0);
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk($sformatf("starve_wait%0d", k), FW'(starve), 0);
      end
      tick();
      chk("starve_on", FW'(starve), 1);
      for (int k = 0; k < 300; k++) tick();
      chk("starve_sat", FW'(dut.scnt), 255);
      chk("starve_hold", FW'(starve), 1);
      chk("starve_head", port_local_o, mk(16'hBEEF));
      port_ack = 1'b1;
      tick();
      port_ack = 1'b0;
      chk("starve_off", FW'(starve), 0);
      chk("starve_cnt", FW'(count), 0);
      chk("err_clean", FW'(err_ack), 0);

      // spurious ack while empty
      port_ack = 1'b1;
      tick();
      port_ack = 1'b0;
      chk("spur_cnt", FW'(count), 0);
      chk("spur_err", FW'(err_ack), 1);
      in_flit = raw(3); in_valid = 1'b1;
      tick();
      in_flit = raw(4);
      tick();
      in_valid = 1'b0;
      chk("spur_sticky", FW'(err_ack), 1);
      chk("pre_rst_cnt", FW'(count), 2);

      // reset mid-operation discards queued flits
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_cnt", FW'(count), 0);
      chk("midrst_port", port_local_o, '0);
      chk("midrst_err", FW'(err_ack), 0);
      chk("midrst_ready", FW'(in_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hr_local_inject_queue.md
Name: hr_local_inject_queue

Overview:
- Per-local-port injection FIFO that sits directly upstream of the hierarchical-ring node's local input (port0_local_i / port1_local_i).
- Accepts flits from the core/NIC and presents the head flit to the node every cycle.
- Holds the head until the node returns the matching local ack, then advances.
- Instantiated twice per node, one per local port; also tracks injection starvation for throttling logic.

Parameters:
- FLIT_W, 144, flit width; matches the node's control word.
- VALID_BIT, 143, bit index of the flit valid flag; a flit with this bit 0 is treated as idle.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- STARVE_W, 8, width of the starvation counter.
- STARVE_TH, 16, threshold at or above which starve asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  core offers in_flit this cycle.
- in_flit  in  FLIT_W  flit from core; the VALID_BIT of a stored flit is forced to 1.
- in_ready  out  1  queue can accept; equals !full and does not depend on port_ack.
- port_local_o  out  FLIT_W  to the node's local input; head flit when non-empty, all-zero when empty.
- port_ack  in  1  node's local ack; the flit on port_local_o this cycle was consumed.
- count  out  $clog2(DEPTH)+1  current occupancy.
- starve  out  1  head has waited at least STARVE_TH cycles without ack.
- err_ack  out  1  sticky; set when port_ack=1 while the queue is empty.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - Pointers and count go to 0; starve counter goes to 0; err_ack goes to 0.
  - Outputs then read: port_local_o=0, in_ready=1, starve=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued flits; port_local_o is 0 the cycle after.
- Push: occurs when in_valid && in_ready. The flit is written at the tail with VALID_BIT set.
- Pop: occurs when port_ack && !empty. The head advances.
- port_local_o: driven combinationally from the head register. No bypass, so a push into an empty queue appears on port_local_o the next cycle (latency 1).
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, in_ready=0 even if port_ack=1 the same cycle; no push occurs.
- Full (count==DEPTH): in_ready=0; in_valid is ignored.
- Empty (count==0):
  - port_local_o=0 (the node sees an idle slot).
  - port_ack is ignored for state and sets err_ack.
- Pointer wrap: read and write pointers wrap modulo DEPTH. count is derived from a separate counter, and full/empty are decoded from count.
- Ordering: strict FIFO; flit contents other than VALID_BIT pass unchanged.
- Starvation counter (scnt, STARVE_W bits):
  - Reset to 0 on a pop or when empty.
  - Otherwise increments by 1 each cycle the queue is non-empty and port_ack=0, saturating at all-ones.
  - starve = (scnt >= STARVE_TH), registered alongside scnt.
- err_ack: cleared only by rst.

Test Plan:
- Reset: rst=1 for 1 edge with in_valid=1 -> count=0, in_ready=1, port_local_o=144'h0, starve=0, err_ack=0; no flit stored.
- Single inject: push flit 144'h8000...00A5 at cycle 0 with port_ack=0 -> port_local_o=8000...00A5 from cycle 1 and held for 3 cycles; ack at cycle 4 -> count 1→0, port_local_o=0 at cycle 5.
- Fill/backpressure: 5 consecutive pushes (payloads 1..5, valid bit 0 on input) with no ack -> first 4 accepted with VALID_BIT forced to 1, in_ready=0 after the 4th, payload 5 dropped; then 4 acks drain 1,2,3,4 in order.
- Full + simultaneous: at count=4, in_valid=1 and port_ack=1 -> pop occurs, push refused, count=3; next cycle push and ack together -> count stays 3; wrap exercised over 12 such cycles with FIFO order preserved.
- Starvation: 1 flit held with port_ack=0 -> starve=0 through 15 waiting cycles, starve=1 once scnt=16, counter saturates at 255 after long hold; ack -> starve=0 next cycle.
- Spurious ack: port_ack=1 while empty -> count stays 0, err_ack=1 and remains 1 through subsequent traffic until rst.
